// File: rtl/cic_ctrl_pkg.sv
// Shared definitions for the CIC decimator sequencing controller.
//   - ctrl_state_e : controller states (IDLE, SETTLE, RUN)
//   - MIN_RATIO    : smallest decimation ratio the controller accepts
//   - settle_cnt_w : width needed to count NUM_STAGES*N suppressed comb outputs
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } ctrl_state_e;

  localparam int unsigned MIN_RATIO = 32'd2;

  function automatic int unsigned settle_cnt_w(input int unsigned num_stages,
                                               input int unsigned n);
    return $clog2(num_stages * n + 32'd1);
  endfunction

endpackage

// File: rtl/cic_valid_pipe.sv
// Valid shift register that follows the comb-chain strobe through the comb
// register stages, so the tap marks the cycle in which the last comb register
// has taken a new value.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of every stage
//   din        : strobe entering the pipe
//   tap        : last stage (DEPTH-1)
module cic_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic tap
);

  logic [DEPTH-1:0] pipe_r;

  // Shift the strobe one stage per clock; clear wipes all stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_r <= '0;
    end else if (clr) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tap = pipe_r[DEPTH-1];

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a CIC decimator (integrators, rate-R downsampler,
// NUM_STAGES comb stages). Produces the integrator enable, the decimation
// strobe that clocks the comb chain and the filter output valid; holds outputs
// back until the comb delay lines carry valid history; applies ratio changes
// only on a decimation boundary.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : run request, low forces IDLE
//   valid_in     : input sample strobe
//   cfg_ratio    : requested decimation ratio
//   cfg_load     : one-cycle load request for cfg_ratio
//   cfg_ack      : one-cycle pulse, request processed
//   cfg_err      : one-cycle pulse with cfg_ack, ratio rejected (< 2)
//   integ_valid  : integrator chain enable
//   comb_valid   : comb chain enable (decimation strobe)
//   out_valid    : filter output valid
//   settled      : comb history full, outputs being delivered
//   out_count    : output counter (only when CIC_CTRL_CNT_EN is defined)
//   cur_ratio    : ratio currently in effect
// Build option: define CIC_CTRL_CNT_EN to add the 16-bit out_count port.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned RATIO_W       = 8,
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned N             = 1,
  parameter int unsigned DEFAULT_RATIO = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               valid_in,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_load,
  output logic               cfg_ack,
  output logic               cfg_err,
  output logic               integ_valid,
  output logic               comb_valid,
  output logic               out_valid,
  output logic               settled,
`ifdef CIC_CTRL_CNT_EN
  output logic [15:0]        out_count,
`endif
  output logic [RATIO_W-1:0] cur_ratio
);

  localparam int unsigned        SCNT_W      = settle_cnt_w(NUM_STAGES, N);
  localparam logic [RATIO_W-1:0] RATIO_RST   = RATIO_W'(DEFAULT_RATIO);
  localparam logic [SCNT_W-1:0]  SETTLE_LAST = SCNT_W'(NUM_STAGES * N - 32'd1);

  ctrl_state_e        state_r, state_s;
  logic [RATIO_W-1:0] phase_r, phase_s;
  logic [RATIO_W-1:0] cur_ratio_r, cur_ratio_s;
  logic [RATIO_W-1:0] pend_ratio_r, pend_ratio_s;
  logic               pend_vld_r, pend_vld_s;
  logic [SCNT_W-1:0]  settle_cnt_r, settle_cnt_s;
  logic               comb_valid_r, comb_valid_s;
  logic               cfg_ack_r, cfg_ack_s;
  logic               cfg_err_r, cfg_err_s;
  logic               pipe_clr_s;
  logic               tap_s;
  logic               accept_s;
  logic               wrap_s;
  logic               cfg_ok_s;
  logic               out_valid_s;

  assign accept_s    = valid_in && (state_r != IDLE);
  assign wrap_s      = accept_s && (phase_r == (cur_ratio_r - RATIO_W'(1)));
  assign cfg_ok_s    = (cfg_ratio >= RATIO_W'(MIN_RATIO));
  assign out_valid_s = tap_s && (state_r == RUN);

  cic_valid_pipe #(.DEPTH(NUM_STAGES)) u_valid_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pipe_clr_s),
    .din   (comb_valid_r),
    .tap   (tap_s)
  );

  // Next-state, phase, ratio and handshake logic.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    cur_ratio_s  = cur_ratio_r;
    pend_ratio_s = pend_ratio_r;
    pend_vld_s   = pend_vld_r;
    settle_cnt_s = settle_cnt_r;
    comb_valid_s = 1'b0;
    cfg_ack_s    = 1'b0;
    cfg_err_s    = 1'b0;
    pipe_clr_s   = 1'b0;
    if (!enable || (state_r == IDLE)) begin
      // Idle or being forced idle: counters and pipe restart, a held ratio
      // takes effect, and new ratios load straight away.
      if (enable) begin
        state_s = SETTLE;
      end else begin
        state_s = IDLE;
      end
      phase_s      = '0;
      settle_cnt_s = '0;
      pipe_clr_s   = 1'b1;
      pend_vld_s   = 1'b0;
      if (pend_vld_r) begin
        cur_ratio_s = pend_ratio_r;
      end else begin
        cur_ratio_s = cur_ratio_r;
      end
      if (cfg_load) begin
        cfg_ack_s = 1'b1;
        if (cfg_ok_s) begin
          cur_ratio_s = cfg_ratio;
        end else begin
          cfg_err_s = 1'b1;
        end
      end else begin
        cfg_ack_s = 1'b0;
      end
    end else begin
      case (state_r)
        SETTLE: begin
          // Comb outputs while history fills are counted and dropped.
          if (tap_s) begin
            settle_cnt_s = settle_cnt_r + SCNT_W'(1);
            if (settle_cnt_r == SETTLE_LAST) begin
              state_s = RUN;
            end else begin
              state_s = SETTLE;
            end
          end else begin
            settle_cnt_s = settle_cnt_r;
          end
        end
        RUN:     state_s = RUN;
        default: state_s = IDLE;
      endcase
      if (wrap_s) begin
        phase_s      = '0;
        comb_valid_s = 1'b1;
        // New ratio changes the gain, so comb history must be rebuilt.
        if (pend_vld_r) begin
          cur_ratio_s  = pend_ratio_r;
          pend_vld_s   = 1'b0;
          state_s      = SETTLE;
          settle_cnt_s = '0;
        end else begin
          pend_vld_s = pend_vld_r;
        end
      end else if (accept_s) begin
        phase_s = phase_r + RATIO_W'(1);
      end else begin
        phase_s = phase_r;
      end
      // Placed after the wrap so a load in the wrap cycle waits for the next one.
      if (cfg_load) begin
        cfg_ack_s = 1'b1;
        if (cfg_ok_s) begin
          pend_ratio_s = cfg_ratio;
          pend_vld_s   = 1'b1;
        end else begin
          cfg_err_s = 1'b1;
        end
      end else begin
        cfg_ack_s = 1'b0;
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      phase_r      <= '0;
      cur_ratio_r  <= RATIO_RST;
      pend_ratio_r <= RATIO_RST;
      pend_vld_r   <= 1'b0;
      settle_cnt_r <= '0;
      comb_valid_r <= 1'b0;
      cfg_ack_r    <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      cur_ratio_r  <= cur_ratio_s;
      pend_ratio_r <= pend_ratio_s;
      pend_vld_r   <= pend_vld_s;
      settle_cnt_r <= settle_cnt_s;
      comb_valid_r <= comb_valid_s;
      cfg_ack_r    <= cfg_ack_s;
      cfg_err_r    <= cfg_err_s;
    end
  end

`ifdef CIC_CTRL_CNT_EN
  logic [15:0] out_count_r;

  // Count delivered outputs; restarts whenever the controller is sent idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count_r <= 16'd0;
    end else if (!enable) begin
      out_count_r <= 16'd0;
    end else if (out_valid_s) begin
      out_count_r <= out_count_r + 16'd1;
    end else begin
      out_count_r <= out_count_r;
    end
  end

  assign out_count = out_count_r;
`endif

  assign integ_valid = accept_s;
  assign comb_valid  = comb_valid_r;
  assign out_valid   = out_valid_s;
  assign settled     = (state_r == RUN);
  assign cfg_ack     = cfg_ack_r;
  assign cfg_err     = cfg_err_r;
  assign cur_ratio   = cur_ratio_r;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Scoreboard bench for cic_decim_ctrl: stimulus pushes hand-computed output
// events (cycle, strobes, ratio, settled) into a queue; a monitor on the
// falling edge pops and compares whenever the DUT raises any strobe.
module tb_cic_decim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       valid_in;
  logic [7:0] cfg_ratio;
  logic       cfg_load;
  logic       cfg_ack;
  logic       cfg_err;
  logic       integ_valid;
  logic       comb_valid;
  logic       out_valid;
  logic       settled;
  logic [7:0] cur_ratio;
`ifdef CIC_CTRL_CNT_EN
  logic [15:0] out_count;
`endif

  always #5 clk = ~clk;

  cic_decim_ctrl #(
    .RATIO_W(8), .NUM_STAGES(3), .N(1), .DEFAULT_RATIO(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .valid_in    (valid_in),
    .cfg_ratio   (cfg_ratio),
    .cfg_load    (cfg_load),
    .cfg_ack     (cfg_ack),
    .cfg_err     (cfg_err),
    .integ_valid (integ_valid),
    .comb_valid  (comb_valid),
    .out_valid   (out_valid),
    .settled     (settled),
`ifdef CIC_CTRL_CNT_EN
    .out_count   (out_count),
`endif
    .cur_ratio   (cur_ratio)
  );

  typedef struct {
    int         cyc;
    logic       comb;
    logic       outv;
    logic       ack;
    logic       err;
    logic [7:0] ratio;
    logic       st;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic en_q;
  int   k0, k2, k3;

  always @(posedge clk) cyc <= cyc + 1;

  // enable as seen by the last clock edge: the controller is active exactly then
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= enable;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic cb, input logic ov, input logic ak,
                      input logic er, input logic [7:0] r, input logic st);
    ev_t e;
    e.cyc = c; e.comb = cb; e.outv = ov; e.ack = ak; e.err = er; e.ratio = r; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: integ_valid every cycle, strobe events against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("integ_valid", {31'd0, integ_valid}, {31'd0, valid_in & en_q});
      if (comb_valid | out_valid | cfg_ack | cfg_err) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event @cyc %0d: comb=%0b out=%0b ack=%0b err=%0b, expected no event",
                   cyc, comb_valid, out_valid, cfg_ack, cfg_err);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.comb !== comb_valid || mon_e.outv !== out_valid ||
              mon_e.ack !== cfg_ack || mon_e.err !== cfg_err || mon_e.ratio !== cur_ratio ||
              mon_e.st !== settled) begin
            miscompares++;
            $display("FAIL event: got cyc=%0d comb=%0b out=%0b ack=%0b err=%0b ratio=%0d settled=%0b, expected cyc=%0d comb=%0b out=%0b ack=%0b err=%0b ratio=%0d settled=%0b",
                     cyc, comb_valid, out_valid, cfg_ack, cfg_err, cur_ratio, settled,
                     mon_e.cyc, mon_e.comb, mon_e.outv, mon_e.ack, mon_e.err, mon_e.ratio, mon_e.st);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; valid_in = 1'b0; cfg_ratio = 8'd0; cfg_load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_comb_valid", {31'd0, comb_valid}, 32'd0);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_cfg_ack",    {31'd0, cfg_ack},    32'd0);
    chk("rst_cfg_err",    {31'd0, cfg_err},    32'd0);
    chk("rst_settled",    {31'd0, settled},    32'd0);
    chk("rst_integ",      {31'd0, integ_valid}, 32'd0);
    chk("rst_cur_ratio",  {24'd0, cur_ratio},  32'd16);
    mon_en = 1'b1;
    @(posedge clk); #1;
    k0 = cyc;
    // R=16, continuous input; then bad load, mid-frame load of 4, disable.
    push(k0+17,  1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 1'b0);
    push(k0+33,  1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 1'b0);
    push(k0+49,  1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 1'b0);
    push(k0+65,  1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 1'b1);
    push(k0+68,  1'b0, 1'b1, 1'b0, 1'b0, 8'd16, 1'b1);
    push(k0+71,  1'b0, 1'b0, 1'b1, 1'b1, 8'd16, 1'b1);
    push(k0+81,  1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 1'b1);
    push(k0+84,  1'b0, 1'b1, 1'b0, 1'b0, 8'd16, 1'b1);
    push(k0+89,  1'b0, 1'b0, 1'b1, 1'b0, 8'd16, 1'b1);
    push(k0+97,  1'b1, 1'b0, 1'b0, 1'b0, 8'd4,  1'b0);
    push(k0+101, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4,  1'b0);
    push(k0+105, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4,  1'b0);
    push(k0+109, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4,  1'b1);
    push(k0+112, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4,  1'b1);
    push(k0+113, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4,  1'b1);
    push(k0+116, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4,  1'b1);
    push(k0+117, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4,  1'b1);
    // Load 2 while idle: immediate.
    push(k0+123, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2,  1'b0);
    // R=2 with a sample every third cycle, restarted from phase 0.
    k2 = k0 + 125;
    push(k2+5,  1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
    push(k2+11, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
    push(k2+17, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
    push(k2+23, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
    push(k2+26, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1);
    push(k2+29, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
    push(k2+32, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1);
    push(k2+35, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
    push(k2+38, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1);
    // Pending load of 5 in SETTLE, applied when disabled.
    k3 = k2 + 45;
    push(k3+3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0);

    enable = 1'b1; valid_in = 1'b1;
    goto(k0+70);  cfg_ratio = 8'd1; cfg_load = 1'b1;
    goto(k0+71);  cfg_load = 1'b0;
    goto(k0+88);  cfg_ratio = 8'd4; cfg_load = 1'b1;
    goto(k0+89);  cfg_load = 1'b0;
    goto(k0+119); enable = 1'b0;
    goto(k0+122); cfg_ratio = 8'd2; cfg_load = 1'b1;
    goto(k0+123); cfg_load = 1'b0;
    goto(k2);     enable = 1'b1;
    for (int j = 0; j < 40; j++) begin
      goto(k2 + 1 + j);
      valid_in = ((j % 3) == 0);
      if (j == 39) enable = 1'b0;
    end
    goto(k2+41);  valid_in = 1'b0;
    goto(k3);     enable = 1'b1;
    goto(k3+2);   cfg_ratio = 8'd5; cfg_load = 1'b1;
    goto(k3+3);   cfg_load = 1'b0;
    goto(k3+4);   enable = 1'b0;
    goto(k3+6);
    chk("pending_on_idle_ratio", {24'd0, cur_ratio}, 32'd5);
    chk("idle_settled", {31'd0, settled}, 32'd0);
    goto(k3+10);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got none, expected event at cyc %0d", mon_e.cyc);
    end

`ifdef CIC_CTRL_CNT_EN
    begin
      int n_out;
      int guard;
      mon_en = 1'b0;
      n_out = 0;
      guard = 0;
      cfg_ratio = 8'd2; cfg_load = 1'b1;
      @(posedge clk); #1 cfg_load = 1'b0;
      enable = 1'b1; valid_in = 1'b1;
      while (n_out < 70000 && guard < 150000) begin
        @(negedge clk);
        guard++;
        if (out_valid) n_out++;
      end
      chk("out_count_outputs_seen", n_out, 32'd70000);
      @(posedge clk); #1;
      chk("out_count_wrap", {16'd0, out_count}, 32'd4464);
      enable = 1'b0; valid_in = 1'b0;
      @(posedge clk); #1;
      chk("out_count_idle_clear", {16'd0, out_count}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Sequencing controller for the CIC decimator datapath: integrator chain, rate-R downsampler, NUM_STAGES comb stages.
- Generates the integrator enable, the decimation strobe that clocks the comb chain, and the output valid.
- Suppresses outputs until the comb delay lines hold valid history.
- Applies runtime ratio changes glitch-free on a decimation boundary.

Parameters:
RATIO_W, 8, width of decimation ratio (R max = 2^RATIO_W-1)
NUM_STAGES, 3, number of comb stages in the datapath (one register each)
N, 1, differential delay of every comb stage
DEFAULT_RATIO, 16, ratio loaded at reset (must be >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; 0 forces IDLE
valid_in  in  1  input sample strobe (one sample per high cycle)
cfg_ratio  in  RATIO_W  requested decimation ratio
cfg_load  in  1  one-cycle request to load cfg_ratio
cfg_ack  out  1  one-cycle pulse: request processed
cfg_err  out  1  one-cycle pulse with cfg_ack: ratio rejected (<2)
integ_valid  out  1  integrator chain enable
comb_valid  out  1  comb chain enable (decimation strobe)
out_valid  out  1  filter output valid
settled  out  1  comb history full, outputs being delivered
cur_ratio  out  RATIO_W  ratio currently in effect

Behaviour:
- Reset: state=IDLE; cur_ratio=DEFAULT_RATIO; phase=0; settle_cnt=0; no pending ratio. All 1-bit outputs are 0.
- States: IDLE, SETTLE, RUN.
- IDLE -> SETTLE when enable=1.
- SETTLE -> RUN after NUM_STAGES*N comb-stage-output strobes have been suppressed.
- Any state -> IDLE in the cycle after enable=0. This applies mid-operation too: phase, settle_cnt and the valid pipe clear.
- integ_valid = valid_in & (state != IDLE), combinational.
- Phase counter: increments on each accepted valid_in and wraps from cur_ratio-1 to 0.
- comb_valid is registered. It is high for exactly one cycle after the edge that accepts valid_in at phase=cur_ratio-1. Latency is 1 cycle, aligned with the integrator output register.
- Valid pipe: a NUM_STAGES-deep shift register fed by comb_valid, advancing every clk. Tap NUM_STAGES-1 marks the last comb register updating.
- out_valid = tap & (state == RUN).
- In SETTLE, each tap pulse increments settle_cnt and is suppressed. settled = (state == RUN).
- Ratio load, IDLE: cfg_ratio >= 2 loads cur_ratio immediately; cfg_ack follows next cycle.
- Ratio load, SETTLE/RUN: the value is held pending and cfg_ack is given next cycle. The pending value is applied at the next phase wrap. On apply, phase=0, state -> SETTLE and settle_cnt=0, because the gain change invalidates comb history.
- A second cfg_load before apply overwrites the pending value.
- cfg_ratio < 2: cfg_ack and cfg_err pulse together; cur_ratio and any pending value are unchanged.
- Simultaneous events:
  - cfg_load in the same cycle as the wrapping valid_in: the new ratio is held pending and applies at the following wrap.
  - enable=0 with a pending ratio: the pending ratio is applied on entry to IDLE.
  - valid_in while IDLE: ignored.
- valid_in may be high every cycle (R >= 2 guarantees comb_valid is never back-to-back).

Optional Feature:
CIC_CTRL_CNT_EN
- Defined: adds output out_count[15:0]. It increments on every out_valid, wraps at 0xFFFF->0, and clears on reset and on entry to IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cic_ctrl_pkg: state enum (IDLE, SETTLE, RUN), MIN_RATIO=2 constant, settle-count width function clog2(NUM_STAGES*N+1).
- Sub-module cic_valid_pipe: parameterised-depth valid shift register with synchronous clear, instantiated once.

Test Plan:
- Reset with DEFAULT_RATIO=16, enable=1, valid_in continuous:
  - comb_valid pulses every 16 cycles, first at cycle 17 after enable.
  - First 3 tap pulses (NUM_STAGES=3, N=1) suppressed; out_valid first seen on the 4th, 3 cycles after its comb_valid.
  - settled rises at that point.
- RUN at R=16, cfg_load cfg_ratio=4 mid-frame:
  - cfg_ack next cycle.
  - cur_ratio changes to 4 only at phase wrap.
  - SETTLE re-entered; then comb_valid every 4 samples.
- cfg_load cfg_ratio=1 -> cfg_ack=cfg_err=1 for one cycle; cur_ratio stays 16.
- valid_in every 3rd cycle at R=2 -> comb_valid every 6 cycles, integ_valid mirrors valid_in, no double strobes.
- enable dropped 2 cycles after a comb_valid:
  - pipe cleared, no out_valid emitted.
  - Re-enable restarts SETTLE with phase=0.
- CIC_CTRL_CNT_EN defined, 70000 outputs -> out_count=70000-65536=4464; returns to 0 after enable=0.
